// File: rtl/seg_pkg.sv
// Shared types and constants for the 8-digit seven-segment scan controller.
// Glyphs are active-low, bit6 = a ... bit0 = g.
package seg_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } seg_state_e;

  localparam int          NUM_DIGITS = 8;
  localparam logic [6:0]  BLANK_SEG  = 7'h7F;

  // Packed so entry k is GLYPH_TBL[k]; listed from F down to 0.
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // True when digit idx (idx >= 1) and every higher digit hold zero.
  function automatic logic lzb_blank(input logic [31:0] data, input logic [2:0] idx);
    return (idx != 3'd0) && ((data >> {idx, 2'b00}) == 32'd0);
  endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational hex nibble to active-low seven-segment glyph decode.
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPH_TBL[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller with a guarded shadow frame buffer.
// Optional leading-zero blanking is built when macro SEG_LZB_EN is defined.
//
// state    | meaning
// ST_GUARD | all anodes off for GUARD_CYC cycles before the current digit
// ST_ON    | current digit lit for DWELL_CYC cycles
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DWELL_CYC = 100000,
  parameter int GUARD_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic [7:0]  digit_en,
  output logic [6:0]  a_to_g,
  output logic [7:0]  an,
  output logic        dp,
  output logic        frame_done
);

  localparam int MAX_CYC = (DWELL_CYC > GUARD_CYC) ? DWELL_CYC : GUARD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC - 1);

  seg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      active_data_q, active_data_d;
  logic [7:0]       active_dp_q, active_dp_d;
  logic [31:0]      shadow_data_q, shadow_data_d;
  logic [7:0]       shadow_dp_q, shadow_dp_d;
  logic             pending_q, pending_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic [3:0]       cur_nib;
  logic [6:0]       cur_glyph;
  logic [6:0]       seg_on;
  logic             accept;

  assign cur_nib = active_data_q[{idx_q, 2'b00} +: 4];

  seg_glyph_dec u_glyph_dec (
    .nib_i (cur_nib),
    .seg_o (cur_glyph)
  );

`ifdef SEG_LZB_EN
  assign seg_on = lzb_blank(active_data_q, idx_q) ? BLANK_SEG : cur_glyph;
`else
  assign seg_on = cur_glyph;
`endif

  // Accepting and promoting are exclusive: accept needs pending low, promote needs it high.
  assign accept = wr_valid & ~pending_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    an_d          = an_q;
    seg_d         = seg_q;
    dp_d          = dp_q;
    // Registered one cycle early so the pulse lands on the last ON cycle of digit 7.
    frame_done_d  = (state_q == ST_ON) && (cnt_q == CNT_W'(1)) && (idx_q == 3'd7);

    if (accept) begin
      shadow_data_d = wr_data;
      shadow_dp_d   = wr_dp;
      pending_d     = 1'b1;
    end

    case (state_q)
      ST_GUARD: begin
        if (cnt_q == '0) begin
          state_d = ST_ON;
          cnt_d   = DWELL_LOAD;
          an_d    = digit_en[idx_q] ? ~(8'b1 << idx_q) : 8'hFF;
          seg_d   = seg_on;
          dp_d    = ~active_dp_q[idx_q];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ON: begin
        if (cnt_q == '0) begin
          state_d = ST_GUARD;
          cnt_d   = GUARD_LOAD;
          idx_d   = idx_q + 3'd1;
          an_d    = 8'hFF;
          seg_d   = BLANK_SEG;
          dp_d    = 1'b1;
          if ((idx_q == 3'd7) && pending_q) begin
            active_data_d = shadow_data_q;
            active_dp_d   = shadow_dp_q;
            pending_d     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_GUARD;
        cnt_d   = GUARD_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_GUARD;
      cnt_q         <= GUARD_LOAD;
      idx_q         <= 3'd0;
      active_data_q <= 32'd0;
      active_dp_q   <= 8'd0;
      shadow_data_q <= 32'd0;
      shadow_dp_q   <= 8'd0;
      pending_q     <= 1'b0;
      an_q          <= 8'hFF;
      seg_q         <= BLANK_SEG;
      dp_q          <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign wr_ready   = ~pending_q;
  assign a_to_g     = seg_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DWELL_CYC = 4, GUARD_CYC = 2 (6-cycle slots, 48-cycle frames).
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic [7:0]  digit_en;
  logic [6:0]  a_to_g;
  logic [7:0]  an;
  logic        dp;
  logic        frame_done;

  seg_scan_ctrl #(
    .DWELL_CYC (4),
    .GUARD_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .digit_en   (digit_en),
    .a_to_g     (a_to_g),
    .an         (an),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] GLY [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int          total;
  int          passed;
  int          pos;
  logic [31:0] exp_data;
  logic [7:0]  exp_dp;
  logic [7:0]  exp_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s pos=%0d got=%0h exp=%0h", tag, pos, got, exp);
  endtask

  task automatic chk_reset_vals();
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_seg", {25'd0, a_to_g}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    chk("rst_rdy", {31'd0, wr_ready}, 32'd1);
  endtask

  // Expected outputs from position within the 48-cycle frame since reset release.
  task automatic check_cycle();
    int          fp;
    int          s;
    bit          on;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  nib;
    fp  = pos % 48;
    s   = fp / 6;
    on  = (fp % 6) >= 2;
    nib = exp_data[4*s +: 4];
    e_an  = 8'hFF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (on) begin
      if (exp_en[s]) e_an = ~(8'b1 << s);
      e_seg = GLY[nib];
`ifdef SEG_LZB_EN
      if ((s >= 1) && ((exp_data >> (4*s)) == 32'd0)) e_seg = 7'h7F;
`endif
      e_dp = ~exp_dp[s];
    end
    chk("an", {24'd0, an}, {24'd0, e_an});
    chk("seg", {25'd0, a_to_g}, {25'd0, e_seg});
    chk("dp", {31'd0, dp}, {31'd0, e_dp});
    chk("frame_done", {31'd0, frame_done}, {31'd0, (fp == 47)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
    check_cycle();
  endtask

  task automatic run_to(input int target);
    while (pos < target) tick();
  endtask

  task automatic offer(input logic [31:0] d, input logic [7:0] p);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_dp    = p;
    tick();
    wr_valid = 1'b0;
    wr_data  = 32'd0;
    wr_dp    = 8'd0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    pos      = 0;
    exp_data = 32'd0;
    exp_dp   = 8'd0;
    check_cycle();
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    pos      = 0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 32'd0;
    wr_dp    = 8'd0;
    digit_en = 8'hFF;
    exp_en   = 8'hFF;
    exp_data = 32'd0;
    exp_dp   = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();

    // Frame 1 shows the cleared buffer while 76543210 waits in shadow.
    release_reset();
    chk("rdy_idle", {31'd0, wr_ready}, 32'd1);
    offer(32'h7654_3210, 8'h00);
    chk("rdy_pend1", {31'd0, wr_ready}, 32'd0);
    run_to(47);
    chk("rdy_at_fd1", {31'd0, wr_ready}, 32'd0);
    exp_data = 32'h7654_3210;
    exp_dp   = 8'h00;
    tick();
    chk("rdy_after_fd1", {31'd0, wr_ready}, 32'd1);

    // Frame A accepted, frame B ignored while A is pending.
    run_to(50);
    offer(32'hFEDC_BA98, 8'h0F);
    chk("rdy_pendA", {31'd0, wr_ready}, 32'd0);
    run_to(60);
    offer(32'h1357_9BDF, 8'hFF);
    chk("rdy_B_ignored", {31'd0, wr_ready}, 32'd0);
    run_to(95);
    chk("rdy_at_fd2", {31'd0, wr_ready}, 32'd0);
    exp_data = 32'hFEDC_BA98;
    exp_dp   = 8'h0F;
    tick();
    chk("rdy_after_fd2", {31'd0, wr_ready}, 32'd1);

    // Write coincident with frame_done while idle lands one full frame later.
    run_to(143);
    offer(32'h89AB_CDEF, 8'hA5);
    chk("rdy_pendC", {31'd0, wr_ready}, 32'd0);
    run_to(191);
    exp_data = 32'h89AB_CDEF;
    exp_dp   = 8'hA5;
    tick();
    chk("rdy_after_fd4", {31'd0, wr_ready}, 32'd1);

    // Digit 2 disabled; re-enabling mid-ON of digit 2 must not light it until a later ON entry.
    digit_en = 8'b1111_1011;
    exp_en   = 8'b1111_1011;
    run_to(207);
    digit_en = 8'hFF;
    run_to(211);
    exp_en   = 8'hFF;
    run_to(239);

    // Pending frame D discarded by a reset in the middle of digit 5's ON phase.
    tick();
    offer(32'hDEAD_BEEF, 8'hFF);
    chk("rdy_pendD", {31'd0, wr_ready}, 32'd0);
    run_to(273);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();

    release_reset();
    chk("rdy_post_rst", {31'd0, wr_ready}, 32'd1);
    offer(32'h0000_0305, 8'h01);
    run_to(47);
    exp_data = 32'h0000_0305;
    exp_dp   = 8'h01;
    tick();
    run_to(60);
    offer(32'h0000_0000, 8'h00);
    run_to(95);
    exp_data = 32'h0000_0000;
    exp_dp   = 8'h00;
    tick();
    run_to(143);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
